wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2_pkg.sv | 20 ++
 rtl/wb_arbiter2_watchdog.sv | 44 ++++
 rtl/wb_arbiter2.sv | 176 +++++++++++++++++
 tb/tb_wb_arbiter2.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter2_pkg.sv
// wb_arbiter2_pkg
//   Shared definitions for the two-master Wishbone arbiter:
//   - arb_state_t : arbiter FSM states (IDLE, GNT_INST, GNT_DATA)
//   - DEFAULT_TIMEOUT : default number of cycles a granted strobe may wait
//     for ram_ack before the arbiter aborts it
//   - GRANT_INST / GRANT_DATA : encoding of the last-grant register
package wb_arbiter2_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    GNT_INST = 2'd1,
    GNT_DATA = 2'd2
  } arb_state_t;

  localparam int DEFAULT_TIMEOUT = 255;

  localparam logic GRANT_INST = 1'b0;
  localparam logic GRANT_DATA = 1'b1;

endpackage

// File: rtl/wb_arbiter2_watchdog.sv
// wb_watchdog
//   Counts cycles in which the granted strobe is stalled and flags the
//   cycle in which the stall count reaches TIMEOUT.
//   Ports:
//     clk     - rising-edge clock
//     reset   - asynchronous active-high reset, clears the counter
//     clr     - synchronous clear (slave acked, or grant is ending)
//     busy    - this cycle is a stalled strobe (stb high, no ack)
//     expired - combinational: this busy cycle is the TIMEOUT-th one
module wb_watchdog
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic busy,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] CNT_MAX  = W'(TIMEOUT);
  localparam logic [W-1:0] CNT_LAST = W'(TIMEOUT - 1);

  logic [W-1:0] count_reg;

  // count_reg holds the number of stalled cycles already completed, so
  // the TIMEOUT-th stalled cycle is the one that starts with TIMEOUT-1.
  // The counter saturates at TIMEOUT instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (busy && (count_reg != CNT_MAX)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  // busy already excludes ram_ack, so an ack in the final cycle wins.
  assign expired = busy && (count_reg >= CNT_LAST);

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2
//   Round-robin arbiter sharing one Wishbone classic slave (RAM) between
//   an instruction-fetch master (inst_*) and a load/store master (data_*).
//   Ports:
//     clk, reset            - clock and asynchronous active-high reset
//     inst_* (master 0)     - addr/wdata/sel/we/cyc/stb in; rdata/ack/err out
//     data_* (master 1)     - same signal set as master 0
//     ram_*  (slave side)   - addr/wdata/sel/we/cyc/stb out; rdata/ack in
//   A grant holds while the granted master keeps cyc high; every grant is
//   followed by at least one IDLE cycle. A stalled strobe is aborted with a
//   one-cycle err pulse after TIMEOUT wait cycles.
module wb_arbiter2
  import wb_arbiter2_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic        clk,
  input  logic        reset,
  // master 0: instruction fetch
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  input  logic [3:0]  inst_sel,
  input  logic        inst_we,
  input  logic        inst_cyc,
  input  logic        inst_stb,
  output logic [31:0] inst_rdata,
  output logic        inst_ack,
  output logic        inst_err,
  // master 1: load/store
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  input  logic [3:0]  data_sel,
  input  logic        data_we,
  input  logic        data_cyc,
  input  logic        data_stb,
  output logic [31:0] data_rdata,
  output logic        data_ack,
  output logic        data_err,
  // shared slave
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_sel,
  output logic        ram_we,
  output logic        ram_cyc,
  output logic        ram_stb,
  input  logic [31:0] ram_rdata,
  input  logic        ram_ack
);

  arb_state_t state_reg, state_next;
  logic       last_grant_reg, last_grant_next;

  logic       inst_req, data_req;
  logic [1:0] grant_vec;    // [0] inst granted, [1] data granted
  logic [1:0] ack_vec;
  logic [1:0] err_vec;
  logic       gnt_cyc, gnt_stb;
  logic       wd_busy, wd_clr, wd_expired;
  logic       timeout_fire;

  assign inst_req  = inst_cyc & inst_stb;
  assign data_req  = data_cyc & data_stb;
  assign grant_vec = {state_reg == GNT_DATA, state_reg == GNT_INST};

  // Raw cyc/stb of whichever master holds the grant (0 in IDLE).
  always_comb begin
    gnt_cyc = 1'b0;
    gnt_stb = 1'b0;
    if (grant_vec[0]) begin
      gnt_cyc = inst_cyc;
      gnt_stb = inst_stb;
    end else if (grant_vec[1]) begin
      gnt_cyc = data_cyc;
      gnt_stb = data_stb;
    end
  end

  // Stall detection uses the unforced strobe so there is no path from the
  // timeout back into its own condition.
  assign wd_busy      = gnt_cyc & gnt_stb & ~ram_ack;
  assign timeout_fire = wd_expired;
  assign wd_clr       = ram_ack | (state_next == IDLE);

  wb_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .reset  (reset),
    .clr    (wd_clr),
    .busy   (wd_busy),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GRANT_INST;
    end else begin
      state_reg      <= state_next;
      last_grant_reg <= last_grant_next;
    end
  end

  // Grants are only issued from IDLE, which guarantees the dead cycle
  // between consecutive grants.
  always_comb begin
    state_next      = state_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      IDLE: begin
        if (inst_req && data_req) begin
          if (last_grant_reg == GRANT_DATA) begin
            state_next      = GNT_INST;
            last_grant_next = GRANT_INST;
          end else begin
            state_next      = GNT_DATA;
            last_grant_next = GRANT_DATA;
          end
        end else if (data_req) begin
          state_next      = GNT_DATA;
          last_grant_next = GRANT_DATA;
        end else if (inst_req) begin
          state_next      = GNT_INST;
          last_grant_next = GRANT_INST;
        end
      end
      GNT_INST: if (timeout_fire || !inst_cyc) state_next = IDLE;
      GNT_DATA: if (timeout_fire || !data_cyc) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Slave-side mux; everything is 0 in IDLE and cyc/stb are pulled low in
  // the cycle the timeout fires.
  always_comb begin
    ram_addr  = '0;
    ram_wdata = '0;
    ram_sel   = '0;
    ram_we    = 1'b0;
    ram_cyc   = 1'b0;
    ram_stb   = 1'b0;
    case (state_reg)
      GNT_INST: begin
        ram_addr  = inst_addr;
        ram_wdata = inst_wdata;
        ram_sel   = inst_sel;
        ram_we    = inst_we;
        ram_cyc   = inst_cyc & ~timeout_fire;
        ram_stb   = inst_stb & ~timeout_fire;
      end
      GNT_DATA: begin
        ram_addr  = data_addr;
        ram_wdata = data_wdata;
        ram_sel   = data_sel;
        ram_we    = data_we;
        ram_cyc   = data_cyc & ~timeout_fire;
        ram_stb   = data_stb & ~timeout_fire;
      end
      default: ;
    endcase
  end

  // Acks in IDLE (e.g. a late ack after an abort) reach neither master.
  for (genvar gi = 0; gi < 2; gi++) begin : g_route
    assign ack_vec[gi] = ram_ack & grant_vec[gi];
    assign err_vec[gi] = timeout_fire & grant_vec[gi];
  end

  assign inst_ack   = ack_vec[0];
  assign data_ack   = ack_vec[1];
  assign inst_err   = err_vec[0];
  assign data_err   = err_vec[1];
  assign inst_rdata = ram_rdata;
  assign data_rdata = ram_rdata;

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2
//   Directed bench for wb_arbiter2 (TIMEOUT=8). The bench plays both
//   masters and the RAM slave cycle by cycle: inputs are driven 1 time unit
//   after the rising edge and outputs are sampled on the falling edge.
module tb_wb_arbiter2;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic [3:0]  inst_sel;
  logic        inst_we, inst_cyc, inst_stb, inst_ack, inst_err;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  data_sel;
  logic        data_we, data_cyc, data_stb, data_ack, data_err;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;
  logic [3:0]  ram_sel;
  logic        ram_we, ram_cyc, ram_stb, ram_ack;

  int check_cnt = 0;
  int pass_cnt  = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.TIMEOUT(8)) dut (
    .clk(clk), .reset(reset),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_sel(inst_sel),
    .inst_we(inst_we), .inst_cyc(inst_cyc), .inst_stb(inst_stb),
    .inst_rdata(inst_rdata), .inst_ack(inst_ack), .inst_err(inst_err),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_sel(data_sel),
    .data_we(data_we), .data_cyc(data_cyc), .data_stb(data_stb),
    .data_rdata(data_rdata), .data_ack(data_ack), .data_err(data_err),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_sel(ram_sel),
    .ram_we(ram_we), .ram_cyc(ram_cyc), .ram_stb(ram_stb),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    check_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic inst_drive(input logic req, input logic [31:0] addr);
    inst_cyc = req; inst_stb = req; inst_addr = addr;
    inst_we = 1'b0; inst_wdata = 32'h0; inst_sel = 4'hF;
  endtask

  task automatic data_drive(input logic req, input logic we, input logic [31:0] addr,
                            input logic [31:0] wd);
    data_cyc = req; data_stb = req; data_addr = addr;
    data_we = we; data_wdata = wd; data_sel = 4'h3;
  endtask

  // Every master-visible and slave-side control output packed together.
  function automatic logic [31:0] ctl_outs();
    return {20'h0, inst_ack, data_ack, inst_err, data_err,
            ram_cyc, ram_stb, ram_we, 1'b0, ram_sel};
  endfunction

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_addr;
    logic [1:0]  exp_ack;

    reset = 1'b1;
    ram_ack = 1'b0; ram_rdata = 32'h0;
    inst_drive(1'b0, 32'h0);
    data_drive(1'b0, 1'b0, 32'h0, 32'h0);

    // ---------------- reset state ----------------
    step();
    inst_drive(1'b1, 32'h44);          // request while held in reset
    smp();
    check("rst ctl", ctl_outs(), 32'h0);
    check("rst addr", ram_addr, 32'h0);
    step();
    inst_drive(1'b0, 32'h0);
    reset = 1'b0;
    smp();
    check("post-rst ctl", ctl_outs(), 32'h0);
    check("post-rst wdata", ram_wdata, 32'h0);

    // ---------------- inst-only read ----------------
    step(); inst_drive(1'b1, 32'h10); smp();
    check("rd lat0 stb", ram_stb, 1'b0);
    step(); smp();
    check("rd lat1 stb", ram_stb, 1'b1);
    check("rd addr", ram_addr, 32'h10);
    check("rd we/sel", {ram_we, ram_sel}, 5'h0F);
    step(); smp();
    check("rd wait ack", inst_ack, 1'b0);
    step(); ram_ack = 1'b1; ram_rdata = 32'hCAFE_0010; smp();
    check("rd ack", {inst_ack, data_ack}, 2'b10);
    check("rd inst_rdata", inst_rdata, 32'hCAFE_0010);
    check("rd data_rdata", data_rdata, 32'hCAFE_0010);
    $display("txn inst read addr=%h data=%h", ram_addr, inst_rdata);
    step(); ram_ack = 1'b0; ram_rdata = 32'h0; inst_drive(1'b0, 32'h0); smp();
    check("rd ack pulse", {inst_ack, ram_cyc}, 2'b00);
    step(); smp();

    // ---------------- tie: data first, then inst on the second tie ----------------
    step();
    inst_drive(1'b1, 32'h100);
    data_drive(1'b1, 1'b1, 32'h200, 32'h1234_5678);
    smp();
    check("tie idle cyc", ram_cyc, 1'b0);
    step(); smp();
    check("tie1 grant addr", ram_addr, 32'h200);
    check("tie1 wdata", ram_wdata, 32'h1234_5678);
    check("tie1 we/sel", {ram_we, ram_sel}, 5'h13);
    step(); ram_ack = 1'b1; smp();
    check("tie1 ack", {inst_ack, data_ack}, 2'b01);
    $display("txn data write addr=%h data=%h", ram_addr, ram_wdata);
    step(); ram_ack = 1'b0; data_drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
    check("tie1 release cyc", ram_cyc, 1'b0);
    step(); data_drive(1'b1, 1'b0, 32'h204, 32'h0); smp();
    check("tie dead cycle", ram_cyc, 1'b0);
    step(); smp();
    check("tie2 grant addr", ram_addr, 32'h100);
    check("tie2 stb", ram_stb, 1'b1);
    step(); ram_ack = 1'b1; smp();
    check("tie2 ack", {inst_ack, data_ack}, 2'b10);
    $display("txn inst read addr=%h data=%h", ram_addr, inst_rdata);
    step(); ram_ack = 1'b0; inst_drive(1'b0, 32'h0); smp();
    step(); smp();
    check("tie2 dead cycle", ram_cyc, 1'b0);
    step(); smp();
    check("tie3 grant addr", ram_addr, 32'h204);
    step(); ram_ack = 1'b1; smp();
    check("tie3 ack", {inst_ack, data_ack}, 2'b01);
    $display("txn data read addr=%h data=%h", ram_addr, data_rdata);
    step(); ram_ack = 1'b0; data_drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
    step(); smp();

    // ---------------- reset mid-transfer ----------------
    step(); inst_drive(1'b1, 32'h300); smp();
    step(); smp();
    check("rst-mid stb before", ram_stb, 1'b1);
    #2; reset = 1'b1; ram_ack = 1'b1;
    #1;
    check("rst-mid cyc/stb", {ram_cyc, ram_stb}, 2'b00);
    check("rst-mid ack", {inst_ack, data_ack, inst_err, data_err}, 4'h0);
    step(); inst_drive(1'b0, 32'h0); smp();
    check("rst-mid held ctl", ctl_outs(), 32'h0);
    step(); ram_ack = 1'b0; reset = 1'b0; smp();
    check("rst-mid after ctl", ctl_outs(), 32'h0);
    step(); smp();
    check("rst-mid after addr", ram_addr, 32'h0);
    $display("txn reset during inst transfer addr=%h", 32'h300);

    // ---------------- starvation: grants alternate data/inst ----------------
    step();
    inst_drive(1'b1, 32'h400);
    data_drive(1'b1, 1'b0, 32'h500, 32'h0);
    smp();
    for (int r = 0; r < 4; r++) begin
      exp_addr = (r % 2 == 0) ? 32'h500 : 32'h400;
      exp_ack  = (r % 2 == 0) ? 2'b01 : 2'b10;
      step(); ram_ack = 1'b1; smp();
      check($sformatf("starve grant %0d", r), ram_addr, exp_addr);
      check($sformatf("starve ack %0d", r), {inst_ack, data_ack}, exp_ack);
      $display("txn starve round %0d addr=%h", r, ram_addr);
      step(); ram_ack = 1'b0;
      if (r % 2 == 0) data_drive(1'b0, 1'b0, 32'h0, 32'h0);
      else            inst_drive(1'b0, 32'h0);
      smp();
      check($sformatf("starve release %0d", r), ram_cyc, 1'b0);
      step();
      if (r < 3) begin
        if (r % 2 == 0) data_drive(1'b1, 1'b0, 32'h500, 32'h0);
        else            inst_drive(1'b1, 32'h400);
      end
      smp();
      check($sformatf("starve idle %0d", r), ram_stb, 1'b0);
    end
    inst_drive(1'b0, 32'h0);
    data_drive(1'b0, 1'b0, 32'h0, 32'h0);
    step(); smp();

    // ---------------- abort, then late ack in IDLE ----------------
    step(); data_drive(1'b1, 1'b0, 32'h600, 32'h0); smp();
    step(); smp();
    check("abort grant", {ram_stb, ram_addr[15:0]}, {1'b1, 16'h0600});
    step(); data_drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
    check("abort drop cyc", ram_cyc, 1'b0);
    step(); ram_ack = 1'b1; ram_rdata = 32'h0BAD; smp();
    check("abort late ack", {inst_ack, data_ack, ram_cyc}, 3'b000);
    $display("txn data aborted addr=%h", 32'h600);
    step(); ram_ack = 1'b0; ram_rdata = 32'h0; smp();

    // ---------------- timeout with a silent slave ----------------
    step(); data_drive(1'b1, 1'b0, 32'h700, 32'h0); smp();
    for (int w = 1; w <= 7; w++) begin
      step(); smp();
      check($sformatf("to wait %0d", w), {ram_stb, data_err}, 2'b10);
    end
    step(); smp();
    check("to expire", {ram_cyc, ram_stb, data_err, inst_err}, 4'b0010);
    step(); smp();
    check("to idle next", {ram_stb, data_err}, 2'b00);
    $display("txn data timeout addr=%h", 32'h700);
    step(); data_drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
    step(); smp();

    // ---------------- ack exactly on the timeout cycle ----------------
    step(); data_drive(1'b1, 1'b0, 32'h704, 32'h0); smp();
    for (int w = 1; w <= 7; w++) begin
      step(); smp();
    end
    check("to8 pre ack stb", ram_stb, 1'b1);
    step(); ram_ack = 1'b1; ram_rdata = 32'h88; smp();
    check("to8 ack wins", {data_ack, data_err, ram_stb}, 3'b101);
    check("to8 rdata", data_rdata, 32'h88);
    $display("txn data read at timeout addr=%h data=%h", ram_addr, data_rdata);
    step(); ram_ack = 1'b0; data_drive(1'b0, 1'b0, 32'h0, 32'h0); smp();
    check("to8 no err after", {data_err, data_ack}, 2'b00);
    step(); smp();

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
